bcd_serial_addsub_ctrl: RTL and testbench
=========================================

// Module: bcd_serial_addsub_ctrl
// PURPOSE
//  Sequencer that drives one shared single-digit BCD add/subtract unit over multi-digit operands.
//  Processes one digit per clock, least significant digit (LSD) first, with a registered digit carry/borrow.
//  Subtraction is computed as A + 9's-complement(B) + 1.
//  Sits between the operand registers and the result bus of the BCD arithmetic path.
// PARAMETERS
//  DIGITS   4   number of BCD digits per operand (>=2); operand width = 4*DIGITS
// PORTS
//  clk        in   1          single clock; all state updates on the rising edge
//  rst        in   1          asynchronous reset, active-high
//  start      in   1          request a new operation; sampled only while busy=0
//  mode       in   1          0 = add, 1 = subtract (A-B); sampled with start
//  a          in   4*DIGITS   operand A, packed BCD; sampled with start
//  b          in   4*DIGITS   operand B, packed BCD; sampled with start
//  busy       out  1          operation in progress
//  done       out  1          one-cycle pulse: result, carry_out and err are valid
//  result     out  4*DIGITS   packed BCD result; held until the next accepted start
//  carry_out  out  1          add: decimal carry out; sub: 1 = no borrow (A>=B)
//  err        out  1          an invalid digit (>9) was seen in a or b at start
// BEHAVIOUR
//  Reset (async, any state):
//   - state=IDLE; busy=0, done=0, result=0, carry_out=0, err=0.
//   - digit index=0; operand shift registers cleared.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE/DONE: busy=0. When start=1 at an edge:
//   - latch a, b, mode; set carry register = mode.
//   - index=0; state=RUN; busy=1.
//  RUN: each edge consumes the current LSD pair.
//   - Subtract: B digit replaced by 9-b.
//   - Digit sum s = a_d + b_d' + c. If s>9: digit = s+6 (low 4 bits), c=1; else digit = s, c=0.
//   - Result digit shifts in at the MS end; operands shift right by 4; index increments.
//   - On the edge processing index DIGITS-1: state=DONE, carry_out=c, done=1, busy=0.
//  Latency: start edge k -> done high after edge k+DIGITS (4 cycles at default); done lasts 1 cycle.
//  Back-to-back: start while in DONE is accepted; the done pulse still lasts exactly 1 cycle.
//  start while busy=1 is ignored; a, b and mode changes during RUN have no effect.
//  Subtract with borrow (carry_out=0): result is the 10's complement (10^DIGITS - (B-A)).
//  Reset asserted mid-RUN: operation aborted, no done pulse, outputs return to reset values.
// CONFIGURATION
//  BCD_ERR_CHECK_EN defined:
//   - at accepted start, err=1 if any digit of a or b exceeds 9, held until the next start.
//   - the operation still runs; result is undefined when err=1.
//  BCD_ERR_CHECK_EN undefined: err tied 0; no check logic.
// STRUCTURE
//  Shared package bcd_pkg:
//   - DIGIT_W=4, BCD_NINE=4'd9, BCD_SIX=4'd6.
//   - state enum {IDLE, RUN, DONE}.
//  Sub-module bcd_digit_addsub (combinational):
//   - inputs a_d, b_d, mode, cin; outputs d, cout.
//   - performs the 9's complement and the +6 correction.
//  This block holds the FSM, index counter, operand/result shift registers and carry register.
// TESTING
//  Test 1: add, a=16'h1234, b=16'h5678 -> after 4 cycles result=16'h6912, carry_out=0, done 1 cycle.
//  Test 2: add, a=16'h9999, b=16'h0001 -> result=16'h0000, carry_out=1.
//  Test 3: sub, a=16'h5000, b=16'h1234 -> result=16'h3766, carry_out=1.
//  Test 4: sub, a=16'h1234, b=16'h5000 -> result=16'h6234, carry_out=0.
//  Test 5: start pulsed during RUN with different a -> ignored; first result unchanged.
//  Test 6: rst asserted at RUN index 2 -> busy=0, result=0, no done pulse; fresh start completes normally.
//  Test 7: BCD_ERR_CHECK_EN, a=16'h12A4 -> err=1 at done; with the macro off, err stays 0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD add/subtract path: digit constants and sequencer states.
package bcd_pkg;

   localparam int          DIGIT_W  = 4;
   localparam logic [3:0]  BCD_NINE = 4'd9;
   localparam logic [3:0]  BCD_SIX  = 4'd6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/bcd_serial_addsub_ctrl_if.sv
// Operand/result bus between the BCD operand registers, the serial sequencer and the result bus.
interface bcd_serial_addsub_ctrl_if #(
   parameter int DIGITS = 4
);
   logic                  start;
   logic                  mode;
   logic [4*DIGITS-1:0]   a;
   logic [4*DIGITS-1:0]   b;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   result;
   logic                  carry_out;
   logic                  err;

   modport master (
      output start, mode, a, b,
      input  busy, done, result, carry_out, err
   );

   modport slave (
      input  start, mode, a, b,
      output busy, done, result, carry_out, err
   );
endinterface

// File: rtl/bcd_digit_addsub.sv
// Single-digit BCD add/subtract cell: optional 9's complement of b_d, then decimal +6 correction.
module bcd_digit_addsub
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] a_d,
   input  logic [DIGIT_W-1:0] b_d,
   input  logic               mode,
   input  logic               cin,
   output logic [DIGIT_W-1:0] d,
   output logic               cout
);

   logic [DIGIT_W-1:0] b_eff;
   logic [DIGIT_W:0]   sum;

   always_comb begin
      b_eff = mode ? (BCD_NINE - b_d) : b_d;
      sum   = {1'b0, a_d} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
      if (sum > 5'd9) begin
         d    = sum[DIGIT_W-1:0] + BCD_SIX;
         cout = 1'b1;
      end else begin
         d    = sum[DIGIT_W-1:0];
         cout = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_serial_addsub_ctrl.sv
// Digit-serial BCD add/subtract sequencer, LSD first, one digit per clock.
// Optional digit-validity flag on err is built when BCD_ERR_CHECK_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, result/carry_out held
// RUN   | one digit pair consumed per clock
// DONE  | single-cycle done pulse; start accepted here too
module bcd_serial_addsub_ctrl
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   bcd_serial_addsub_ctrl_if.slave   bus
);

   localparam int                 W        = DIGIT_W * DIGITS;
   localparam int                 IDX_W    = $clog2(DIGITS);
   localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DIGITS - 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [W-1:0]       a_sh_q, a_sh_d;
   logic [W-1:0]       b_sh_q, b_sh_d;
   logic [W-1:0]       res_q, res_d;
   logic               mode_q, mode_d;
   logic               carry_q, carry_d;
   logic               carry_out_q, carry_out_d;

   logic               accept;
   logic               last_digit;
   logic [DIGIT_W-1:0] dig;
   logic               dig_cout;

   bcd_digit_addsub u_digit (
      .a_d  (a_sh_q[DIGIT_W-1:0]),
      .b_d  (b_sh_q[DIGIT_W-1:0]),
      .mode (mode_q),
      .cin  (carry_q),
      .d    (dig),
      .cout (dig_cout)
   );

   assign accept     = bus.start && (state_q != RUN);
   assign last_digit = (idx_q == IDX_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         res_q       <= '0;
         mode_q      <= 1'b0;
         carry_q     <= 1'b0;
         carry_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         res_q       <= res_d;
         mode_q      <= mode_d;
         carry_q     <= carry_d;
         carry_out_q <= carry_out_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (last_digit) state_d = DONE;
         DONE:    state_d = bus.start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Carry register is preloaded with mode so subtraction gets its +1 on the first digit.
   always_comb begin
      idx_d       = idx_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      res_d       = res_q;
      mode_d      = mode_q;
      carry_d     = carry_q;
      carry_out_d = carry_out_q;
      if (accept) begin
         idx_d   = '0;
         a_sh_d  = bus.a;
         b_sh_d  = bus.b;
         mode_d  = bus.mode;
         carry_d = bus.mode;
      end else if (state_q == RUN) begin
         idx_d   = idx_q + IDX_W'(1);
         a_sh_d  = {{DIGIT_W{1'b0}}, a_sh_q[W-1:DIGIT_W]};
         b_sh_d  = {{DIGIT_W{1'b0}}, b_sh_q[W-1:DIGIT_W]};
         res_d   = {dig, res_q[W-1:DIGIT_W]};
         carry_d = dig_cout;
         if (last_digit) carry_out_d = dig_cout;
      end
   end

   always_comb begin
      bus.busy      = (state_q == RUN);
      bus.done      = (state_q == DONE);
      bus.result    = res_q;
      bus.carry_out = carry_out_q;
   end

`ifdef BCD_ERR_CHECK_EN
   logic err_q, err_d;

   function automatic logic has_bad_digit(input logic [W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[i*DIGIT_W +: DIGIT_W] > BCD_NINE) bad = 1'b1;
      end
      return bad;
   endfunction

   always_comb begin
      err_d = err_q;
      if (accept) err_d = has_bad_digit(bus.a) || has_bad_digit(bus.b);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub_ctrl.sv
// Self-checking bench for bcd_serial_addsub_ctrl: vector table plus corner sequences, scoreboard on done.
module tb_bcd_serial_addsub_ctrl;

   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bcd_serial_addsub_ctrl_if #(.DIGITS(DIGITS)) bus ();

   bcd_serial_addsub_ctrl #(.DIGITS(DIGITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic         mode;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_res;
      logic         exp_co;
      logic         exp_err;
      logic         chk_res;
   } vec_t;

   typedef struct {
      logic [W-1:0] exp_res;
      logic         exp_co;
      logic         exp_err;
      logic         chk_res;
      int           t_drive;
   } sb_t;

   sb_t  sb_q[$];
   sb_t  mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   logic prev_done = 1'b0;

`ifdef BCD_ERR_CHECK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int bcd2int(input logic [W-1:0] v);
      int r;
      r = 0;
      for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
      return r;
   endfunction

   function automatic logic [W-1:0] int2bcd(input int v);
      logic [W-1:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[i*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic model(input logic mode, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic co);
      int ia, ib, m;
      ia = bcd2int(a);
      ib = bcd2int(b);
      m  = 10 ** DIGITS;
      if (!mode) begin
         co  = (ia + ib) >= m;
         res = int2bcd((ia + ib) % m);
      end else if (ia >= ib) begin
         co  = 1'b1;
         res = int2bcd(ia - ib);
      end else begin
         co  = 1'b0;
         res = int2bcd(m - (ib - ia));
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.done) begin
         chk("done_one_cycle", {31'd0, prev_done}, 32'd0);
         chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
         end else begin
            mon_e = sb_q.pop_front();
            chk("latency", cyc - mon_e.t_drive, DIGITS + 1);
            if (mon_e.chk_res) begin
               chk("result", {16'd0, bus.result}, {16'd0, mon_e.exp_res});
               chk("carry_out", {31'd0, bus.carry_out}, {31'd0, mon_e.exp_co});
            end
            chk("err", {31'd0, bus.err}, {31'd0, mon_e.exp_err});
         end
      end
      prev_done = bus.done;
   end

   // Called at a negedge; leaves start low one negedge later.
   task automatic issue(input logic mode, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input logic exp_co, input logic exp_err,
                        input logic chk_res);
      sb_t e;
      bus.start = 1'b1;
      bus.mode  = mode;
      bus.a     = a;
      bus.b     = b;
      e.exp_res = exp_res;
      e.exp_co  = exp_co;
      e.exp_err = exp_err;
      e.chk_res = chk_res;
      e.t_drive = cyc;
      sb_q.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 4 * DIGITS; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=no_done required=done", tag);
         sb_q.delete();
      end
   endtask

   vec_t vecs[$];
   logic [W-1:0] ra, rb, rres;
   logic rco, rmode;

   initial begin
      vecs.push_back('{1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 16'h1234, 16'h5000, 16'h6234, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 16'h4321, 16'h4321, 16'h0000, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 16'h0000, 16'h0001, 16'h9999, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 16'h5555, 16'h4445, 16'h0000, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 16'h0999, 16'h0001, 16'h1000, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 16'h12A4, 16'h0000, 16'h0000, 1'b0, ERR_EXP, 1'b0});
      vecs.push_back('{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1});

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.mode  = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_result", {16'd0, bus.result}, 32'd0);
      chk("rst_carry_out", {31'd0, bus.carry_out}, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Odd entries follow immediately in the DONE cycle, even ones after an idle gap.
      foreach (vecs[i]) begin
         issue(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].exp_res,
               vecs[i].exp_co, vecs[i].exp_err, vecs[i].chk_res);
         wait_done("table");
         if (i % 2 == 1) @(negedge clk);
      end
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         ra    = int2bcd(int'($urandom_range(0, 9999)));
         rb    = int2bcd(int'($urandom_range(0, 9999)));
         rmode = 1'($urandom_range(0, 1));
         model(rmode, ra, rb, rres, rco);
         issue(rmode, ra, rb, rres, rco, 1'b0, 1'b1);
         wait_done("random");
      end
      @(negedge clk);

      // start during RUN with different operands must be ignored.
      issue(1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b1);
      bus.start = 1'b1;
      bus.mode  = 1'b1;
      bus.a     = 16'h9999;
      @(negedge clk);
      bus.start = 1'b0;
      bus.b     = 16'h0007;
      wait_done("ignore_start");
      @(negedge clk);
      @(negedge clk);

      // Reset at digit index 2 aborts the operation without a done pulse.
      issue(1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("mid_busy_before_rst", {31'd0, bus.busy}, 32'd1);
      rst = 1'b1;
      sb_q.delete();
      #1;
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_result", {16'd0, bus.result}, 32'd0);
      chk("abort_done", {31'd0, bus.done}, 32'd0);
      chk("abort_carry_out", {31'd0, bus.carry_out}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (DIGITS + 2) @(negedge clk);
      issue(1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b1, 1'b0, 1'b1);
      wait_done("after_abort");

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb_q.size(), 32'd0);
      chk("held_result", {16'd0, bus.result}, 32'h3766);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
